// File: rtl/disp_pkg.sv
// Shared definitions for the display path: converter FSM states, special
// digit codes and BCD geometry.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam logic [3:0] DIG_ERR  = 4'hE;
  localparam logic [3:0] DIG_NINE = 4'h9;

  localparam int NUM_DIGITS = 5;
  localparam int BCD_W      = 20;

  // Largest displayable value in hundredths (999.99).
  localparam int DEF_MAX_VAL = 99999;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more so the
// following left shift carries correctly into the next decade.
module bcd_adj3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Combinational add-3 correction.
  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_5dig.sv
// Sequential binary-to-BCD converter (shift-and-add-3) producing five
// registered digits for the seven-segment driver. Digits only change on
// a completed conversion, so the display never shows partial results.
//
// Handshake: a sample is accepted on a clock edge where in_valid && in_ready.
// in_ready is high only in IDLE; in_valid at any other time is ignored and
// the sample is lost. out_valid pulses for one cycle when new digits load.
//
// Optional macro BCD_OVF_SAT_EN: overflowing samples load 9,9,9,9,9 instead
// of the E,E,E,E,E error pattern; ovf is set in both builds.
module bin2bcd_5dig
  import disp_pkg::*;
#(
  parameter int IN_W    = 17,
  parameter int MAX_VAL = DEF_MAX_VAL
) (
  input  logic            clk,
  input  logic            res,
  input  logic            in_valid,
  input  logic [IN_W-1:0] bin_in,
  output logic            in_ready,
  output logic            out_valid,
  output logic            ovf,
  output logic [3:0]      num1,
  output logic [3:0]      num2,
  output logic [3:0]      num3,
  output logic [3:0]      num4,
  output logic [3:0]      num5,
  output logic [1:0]      dbg_state
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(IN_W - 1);
  localparam logic [IN_W-1:0]  MAX_VAL_W = IN_W'(MAX_VAL);

`ifdef BCD_OVF_SAT_EN
  localparam logic [3:0] OVF_DIGIT = DIG_NINE;
`else
  localparam logic [3:0] OVF_DIGIT = DIG_ERR;
`endif

  state_e state_q, state_d;
  logic [IN_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0] acc_q, acc_d, acc_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  // Index 4 is the hundreds digit (num1), index 0 the hundredths (num5).
  logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d;

  // One add-3 corrector per accumulator nibble.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .d (acc_q[4*g +: 4]),
      .q (acc_adj[4*g +: 4])
    );
  end

  // Next-state and datapath: accept in IDLE, IN_W shifts, then one load cycle.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_pend_d  = ovf_pend_q;
    ovf_d       = ovf_q;
    dig_d       = dig_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = SHIFT;
          bin_d      = bin_in;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (bin_in > MAX_VAL_W);
        end
      end
      SHIFT: begin
        // Binary MSB enters the accumulator LSB; any carry out of the top
        // nibble is dropped (only reachable for overflowing inputs).
        acc_d = {acc_adj[BCD_W-2:0], bin_q[IN_W-1]};
        bin_d = {bin_q[IN_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = LOAD;
      end
      LOAD: begin
        dig_d       = ovf_pend_q ? {NUM_DIGITS{OVF_DIGIT}} : acc_q;
        ovf_d       = ovf_pend_q;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_pend_q  <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      dig_q       <= '0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_pend_q  <= ovf_pend_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      dig_q       <= dig_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign num1      = dig_q[4];
  assign num2      = dig_q[3];
  assign num3      = dig_q[2];
  assign num4      = dig_q[1];
  assign num5      = dig_q[0];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bin2bcd_5dig.sv
// Testbench for bin2bcd_5dig: directed cases plus random samples compared
// against a decimal-arithmetic reference model.
module tb_bin2bcd_5dig;
  import disp_pkg::*;

  localparam int IN_W = 17;
  localparam int LAT  = IN_W + 1;  // edges from accept to visible out_valid
  localparam int N_RANDOM = 2000;

  logic            clk = 1'b0;
  logic            res;
  logic            in_valid;
  logic [IN_W-1:0] bin_in;
  logic            in_ready;
  logic            out_valid;
  logic            ovf;
  logic [3:0]      num1, num2, num3, num4, num5;
  logic [1:0]      dbg_state;
  logic [20:0]     obs;

  int n_tests = 0;
  int n_fail  = 0;
  logic [20:0] exp_q[$];
  logic [20:0] last_exp;

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  bin2bcd_5dig #(.IN_W(IN_W), .MAX_VAL(99999)) dut (
    .clk       (clk),
    .res       (res),
    .in_valid  (in_valid),
    .bin_in    (bin_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .ovf       (ovf),
    .num1      (num1),
    .num2      (num2),
    .num3      (num3),
    .num4      (num4),
    .num5      (num5),
    .dbg_state (dbg_state)
  );

  assign obs = {ovf, num1, num2, num3, num4, num5};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: decimal digits by division, overflow replaced per build.
  function automatic logic [20:0] ref_model(input int unsigned v);
    int unsigned d1, d2, d3, d4, d5;
    if (v > 99999) begin
`ifdef BCD_OVF_SAT_EN
      return {1'b1, 20'h99999};
`else
      return {1'b1, 20'hEEEEE};
`endif
    end
    d1 = v / 10000;
    d2 = (v / 1000) % 10;
    d3 = (v / 100) % 10;
    d4 = (v / 10) % 10;
    d5 = v % 10;
    return {1'b0, 4'(d1), 4'(d2), 4'(d3), 4'(d4), 4'(d5)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one sample, then follow it to its out_valid, checking that digits
  // hold, in_ready stays low for the conversion, and the result matches.
  task automatic send(input int unsigned v, input bit noise);
    int n;
    int low;
    logic [20:0] e;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check("ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    bin_in   = IN_W'(v);
    exp_q.push_back(ref_model(v));
    tick();
    in_valid = 1'b0;
    bin_in   = IN_W'($urandom_range(0, 131071));
    check("ov_pulse", 32'(out_valid), 32'd0);
    low = in_ready ? 0 : 1;
    n = 0;
    while (n < 40) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        bin_in   = IN_W'(777);
      end else begin
        bin_in   = IN_W'($urandom_range(0, 131071));
      end
      tick();
      n++;
      if (out_valid) break;
      if (!in_ready) low++;
      check("hold", 32'(obs), 32'(last_exp));
    end
    in_valid = 1'b0;
    check("latency", n, LAT);
    check("ready_low", low, LAT);
    check("ready_back", 32'(in_ready), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("digits_%0d", v), 32'(obs), 32'(e));
      last_exp = e;
    end else begin
      check("sb_underflow", 32'(exp_q.size()), 32'd1);
    end
  endtask

  // Stimulus and final report.
  initial begin
    int n;
    int pulses;
    res      = 1'b1;
    in_valid = 1'b0;
    bin_in   = '0;
    last_exp = '0;
    repeat (3) tick();
    check("rst_digits", 32'(obs), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    res = 1'b0;
    tick();

    // Directed cases; consecutive sends are back-to-back.
    send(12345, 1'b0);
    send(0, 1'b0);
    send(99999, 1'b0);
    send(100000, 1'b0);
    send(507, 1'b0);
    send(4321, 1'b1);
    send(131071, 1'b0);
    send(100000, 1'b0);
    send(99999, 1'b0);

    // Reset in the middle of a conversion.
    in_valid = 1'b1;
    bin_in   = IN_W'(31415);
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    res = 1'b1;
    tick();
    check("midrst_digits", 32'(obs), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    res = 1'b0;
    last_exp = '0;
    pulses = 0;
    for (n = 0; n < 25; n++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("midrst_no_load", pulses, 0);
    send(31415, 1'b0);

    // Random samples across the full input range.
    for (int i = 0; i < N_RANDOM; i++) begin
      send($urandom_range(0, 131071), 1'b0);
    end

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
